div_sched: RTL and testbench
============================

DIV_SCHED -- requirements
Module: div_sched

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: the module is asynchronously reset when `rst` is low; all other logic is synchronous to `clk`.
REQ-002 SHALL expose: clk  input  1  system clock, rising-edge.
REQ-003 SHALL expose: rst  input  1  asynchronous active-low reset.
REQ-004 SHALL expose: start_i  input  1  request a divide; sampled only in IDLE.
REQ-005 SHALL expose: op_i  input  3  funct3: 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL expose: dividend_i  input  32  rs1 value.
REQ-007 SHALL expose: divisor_i  input  32  rs2 value.
REQ-008 SHALL expose: reg_waddr_i  input  5  destination register.
REQ-009 SHALL expose: flush_i  input  1  cancel the in-flight divide (jump or interrupt).
REQ-010 SHALL expose: result_o  output  32  quotient or remainder; valid only while ready_o is high.
REQ-011 SHALL expose: ready_o  output  1  one-cycle completion pulse; doubles as the register write enable.
REQ-012 SHALL expose: reg_waddr_o  output  5  captured destination register.
REQ-013 SHALL expose: busy_o  output  1  a divide is in flight (state is not IDLE).
REQ-014 SHALL expose: hold_req_o  output  1  pipeline hold request to the pipeline controller.

Function
REQ-015 SHALL implement four states: IDLE, START, CALC, END.
REQ-016 IDLE with start_i=1 and flush_i=0 SHALL capture op_i, dividend_i, divisor_i and reg_waddr_i, then go to START.
REQ-017 START with divisor=0 SHALL go directly to END.
- DIV/DIVU result: 0xFFFFFFFF.
- REM/REMU result: the dividend.
REQ-018 START with divisor≠0 SHALL:
- load the unsigned magnitudes (magnitude for signed ops; two's complement of 0x80000000 stays 0x80000000);
- clear the 6-bit iteration counter;
- go to CALC.
REQ-019 CALC SHALL perform one restoring shift-subtract step per cycle and leave for END after exactly 32 steps (counter 0..31).
REQ-020 END SHALL apply sign correction:
- quotient is negated when the signed-op operand signs differ;
- remainder takes the sign of the dividend.
REQ-021 END SHALL assert ready_o=1 for exactly one cycle with result_o and reg_waddr_o valid, then return to IDLE.
REQ-022 Latency from the start_i sample edge (cycle N) SHALL be:
- ready_o at cycle N+34 for normal operands;
- ready_o at cycle N+2 for a zero divisor.
REQ-023 DIV 0x80000000 / 0xFFFFFFFF SHALL produce quotient 0x80000000 and remainder 0 via the normal path.
REQ-024 busy_o SHALL equal (state != IDLE).
REQ-025 hold_req_o SHALL be combinational: busy_o OR (state==IDLE AND start_i AND NOT flush_i), so the pipeline stalls in the same cycle the request arrives.
REQ-026 start_i asserted while busy_o=1 SHALL be ignored.
REQ-027 flush_i=1 in any non-IDLE state SHALL return the block to IDLE on the next edge with no ready_o pulse; flush_i in END SHALL suppress that cycle's ready_o.
REQ-028 When start_i and flush_i are both asserted in IDLE, flush SHALL win and no capture SHALL occur.
REQ-029 result_o and reg_waddr_o SHALL be 0 whenever ready_o=0.

Reset
REQ-030 While rst is low, the state SHALL be IDLE and all registers SHALL be 0: result_o=0, ready_o=0, reg_waddr_o=0, busy_o=0, hold_req_o=0 (start_i is ignored during reset).
REQ-031 Reset asserted mid-operation SHALL abandon the divide immediately and asynchronously, with no ready_o pulse after reset deassertion.

Verification
REQ-032 DIVU 100/7, rd=5, start at N -> ready_o only at N+34, result 14, reg_waddr_o=5; repeat with REMU -> result 2.
REQ-033 DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD (-3); REM of the same operands -> 0xFFFFFFFF (-1); DIV 7 / 0xFFFFFFFE -> 0xFFFFFFFD.
REQ-034 Zero divisor: DIVU 5/0 -> 0xFFFFFFFF at N+2; REM 0x80000001/0 -> 0x80000001 at N+2; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at N+34.
REQ-035 flush_i pulsed at N+10 -> busy_o=0 from N+11, no ready_o through N+40; a new start at N+12 completes at N+46.
REQ-036 Second start_i while busy (at N+5) is ignored, one ready_o only; start_i with flush_i in IDLE -> hold_req_o=0, busy_o stays 0.
REQ-037 rst asserted low at N+20 -> all outputs 0 in the same cycle; released at N+22 -> no ready_o follows; a subsequent DIVU 9/3 -> 3 with correct latency.

Source files
------------

// File: rtl/div_sched.sv
// Multi-cycle RV32M divider scheduler: captures a DIV/DIVU/REM/REMU request,
// runs a 32-step restoring shift-subtract, applies sign correction and
// emits a one-cycle registered completion pulse with the destination register.
module div_sched (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  input  logic [4:0]  reg_waddr_i,
  input  logic        flush_i,
  output logic [31:0] result_o,
  output logic        ready_o,
  output logic [4:0]  reg_waddr_o,
  output logic        busy_o,
  output logic        hold_req_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    CALC  = 2'd2,
    END   = 2'd3
  } state_t;

  // Two's complement negate; 0x80000000 maps onto itself, which is the
  // correct unsigned magnitude of the most negative operand.
  function automatic logic [31:0] neg32(input logic [31:0] v);
    return (~v) + 32'd1;
  endfunction

  // Unsigned magnitude of an operand, honouring signedness.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? neg32(v) : v;
  endfunction

  state_t      state_r, state_s;
  logic [1:0]  op_r;          // op_r[1]: remainder, op_r[0]: unsigned
  logic [31:0] dividend_r;
  logic [31:0] divisor_r;
  logic [4:0]  waddr_r;
  logic [31:0] rem_r;
  logic [31:0] quo_r;
  logic [31:0] dvs_r;         // divisor magnitude used by the iteration
  logic [5:0]  cnt_r;
  logic        neg_q_r;
  logic        neg_rem_r;
  logic [31:0] result_r;
  logic        ready_r;
  logic [4:0]  waddr_out_r;

  logic        signed_op_s;
  logic        accept_s;
  logic [32:0] trial_s;
  logic [32:0] diff_s;
  logic [31:0] rem_next_s;
  logic [31:0] quo_next_s;
  logic        unused_op;

  // Bit 2 of funct3 is always set for the divide group and carries no information here.
  assign unused_op   = op_i[2];
  assign signed_op_s = ~op_r[0];
  assign accept_s    = (state_r == IDLE) && start_i && !flush_i;

  assign busy_o      = (state_r != IDLE);
  // Stall the pipeline in the very cycle a request arrives; start is ignored during reset.
  assign hold_req_o  = busy_o || (accept_s && rst);

  assign result_o    = result_r;
  assign ready_o     = ready_r;
  assign reg_waddr_o = waddr_out_r;

  // One restoring step: shift the next dividend bit into the partial remainder, subtract if it fits.
  always_comb begin
    trial_s    = {rem_r, quo_r[31]};
    diff_s     = trial_s - {1'b0, dvs_r};
    rem_next_s = trial_s[31:0];
    quo_next_s = {quo_r[30:0], 1'b0};
    if (!diff_s[32]) begin
      rem_next_s = diff_s[31:0];
      quo_next_s = {quo_r[30:0], 1'b1};
    end else begin
      rem_next_s = trial_s[31:0];
      quo_next_s = {quo_r[30:0], 1'b0};
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; a flush in any busy state returns to IDLE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_i && !flush_i) begin
          state_s = START;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (flush_i) begin
          state_s = IDLE;
        end else if (divisor_r == 32'd0) begin
          state_s = END;
        end else begin
          state_s = CALC;
        end
      end
      CALC: begin
        if (flush_i) begin
          state_s = IDLE;
        end else if (cnt_r == 6'd31) begin
          state_s = END;
        end else begin
          state_s = CALC;
        end
      end
      END:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, sign correction and the registered completion outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_r        <= 2'd0;
      dividend_r  <= 32'd0;
      divisor_r   <= 32'd0;
      waddr_r     <= 5'd0;
      rem_r       <= 32'd0;
      quo_r       <= 32'd0;
      dvs_r       <= 32'd0;
      cnt_r       <= 6'd0;
      neg_q_r     <= 1'b0;
      neg_rem_r   <= 1'b0;
      result_r    <= 32'd0;
      ready_r     <= 1'b0;
      waddr_out_r <= 5'd0;
    end else begin
      ready_r     <= 1'b0;
      result_r    <= 32'd0;
      waddr_out_r <= 5'd0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            op_r       <= op_i[1:0];
            dividend_r <= dividend_i;
            divisor_r  <= divisor_i;
            waddr_r    <= reg_waddr_i;
          end
        end
        START: begin
          if (divisor_r == 32'd0) begin
            // Architectural divide-by-zero results, no sign correction.
            quo_r     <= 32'hFFFF_FFFF;
            rem_r     <= dividend_r;
            neg_q_r   <= 1'b0;
            neg_rem_r <= 1'b0;
          end else begin
            quo_r     <= mag32(dividend_r, signed_op_s);
            rem_r     <= 32'd0;
            dvs_r     <= mag32(divisor_r, signed_op_s);
            cnt_r     <= 6'd0;
            neg_q_r   <= signed_op_s && (dividend_r[31] ^ divisor_r[31]);
            neg_rem_r <= signed_op_s && dividend_r[31];
          end
        end
        CALC: begin
          rem_r <= rem_next_s;
          quo_r <= quo_next_s;
          cnt_r <= cnt_r + 6'd1;
        end
        END: begin
          if (!flush_i) begin
            ready_r     <= 1'b1;
            waddr_out_r <= waddr_r;
            if (op_r[1]) begin
              result_r <= neg_rem_r ? neg32(rem_r) : rem_r;
            end else begin
              result_r <= neg_q_r ? neg32(quo_r) : quo_r;
            end
          end
        end
        default: begin
          cnt_r <= 6'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_sched.sv
// Directed self-checking bench for div_sched: latency, results, zero divisor,
// flush, ignored restart, start+flush in IDLE and mid-operation reset.
module tb_div_sched;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic [4:0]  reg_waddr_i;
  logic        flush_i;
  logic [31:0] result_o;
  logic        ready_o;
  logic [4:0]  reg_waddr_o;
  logic        busy_o;
  logic        hold_req_o;

  int n_cmp;
  int n_err;

  localparam logic [2:0] OP_DIV  = 3'b100;
  localparam logic [2:0] OP_DIVU = 3'b101;
  localparam logic [2:0] OP_REM  = 3'b110;
  localparam logic [2:0] OP_REMU = 3'b111;

  div_sched dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .op_i       (op_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .reg_waddr_i(reg_waddr_i),
    .flush_i    (flush_i),
    .result_o   (result_o),
    .ready_o    (ready_o),
    .reg_waddr_o(reg_waddr_o),
    .busy_o     (busy_o),
    .hold_req_o (hold_req_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Present a request and advance to just after its sampling edge N.
  task automatic drive_start(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] rd);
    op_i        = op;
    dividend_i  = a;
    divisor_i   = b;
    reg_waddr_i = rd;
    flush_i     = 1'b0;
    start_i     = 1'b1;
    tick();
    start_i     = 1'b0;
  endtask

  // Watch a bounded window; k counts edges from now, so k==exp_lat means ready at N+exp_lat.
  task automatic wait_ready(input string tag, input int exp_lat, input logic [31:0] exp_res,
                            input logic [4:0] exp_rd);
    int          first;
    int          pulses;
    logic [31:0] res;
    logic [4:0]  rd;
    logic        leak;
    first  = -1;
    pulses = 0;
    res    = 32'd0;
    rd     = 5'd0;
    leak   = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (ready_o) begin
        pulses++;
        if (first < 0) begin
          first = k;
          res   = result_o;
          rd    = reg_waddr_o;
        end
      end else if (result_o !== 32'd0 || reg_waddr_o !== 5'd0) begin
        leak = 1'b1;
      end
    end
    check({tag, "_latency"}, first, exp_lat);
    check({tag, "_result"}, res, exp_res);
    check({tag, "_waddr"}, {27'd0, rd}, {27'd0, exp_rd});
    check({tag, "_pulses"}, pulses, 32'd1);
    check({tag, "_zero_when_idle"}, {31'd0, leak}, 32'd0);
  endtask

  initial begin
    int pulses;
    n_cmp       = 0;
    n_err       = 0;
    rst         = 1'b0;
    start_i     = 1'b0;
    op_i        = 3'd0;
    dividend_i  = 32'd0;
    divisor_i   = 32'd0;
    reg_waddr_i = 5'd0;
    flush_i     = 1'b0;

    // Reset state.
    tick();
    tick();
    check("rst_result", result_o, 32'd0);
    check("rst_ready", {31'd0, ready_o}, 32'd0);
    check("rst_waddr", {27'd0, reg_waddr_o}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_hold", {31'd0, hold_req_o}, 32'd0);
    rst = 1'b1;
    tick();

    // Unsigned divide / remainder, hold asserted in the request cycle.
    op_i = OP_DIVU; dividend_i = 32'd100; divisor_i = 32'd7; reg_waddr_i = 5'd5;
    start_i = 1'b1;
    #1;
    check("hold_same_cycle", {31'd0, hold_req_o}, 32'd1);
    tick();
    start_i = 1'b0;
    check("busy_after_start", {31'd0, busy_o}, 32'd1);
    wait_ready("divu_100_7", 34, 32'd14, 5'd5);
    drive_start(OP_REMU, 32'd100, 32'd7, 5'd5);
    wait_ready("remu_100_7", 34, 32'd2, 5'd5);

    // Signed cases.
    drive_start(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd10);
    wait_ready("div_m7_2", 34, 32'hFFFF_FFFD, 5'd10);
    drive_start(OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd11);
    wait_ready("rem_m7_2", 34, 32'hFFFF_FFFF, 5'd11);
    drive_start(OP_DIV, 32'd7, 32'hFFFF_FFFE, 5'd12);
    wait_ready("div_7_m2", 34, 32'hFFFF_FFFD, 5'd12);

    // Zero divisor and signed overflow.
    drive_start(OP_DIVU, 32'd5, 32'd0, 5'd1);
    wait_ready("divu_5_0", 2, 32'hFFFF_FFFF, 5'd1);
    drive_start(OP_REM, 32'h8000_0001, 32'd0, 5'd2);
    wait_ready("rem_x_0", 2, 32'h8000_0001, 5'd2);
    drive_start(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3);
    wait_ready("div_ovf", 34, 32'h8000_0000, 5'd3);
    drive_start(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4);
    wait_ready("rem_ovf", 34, 32'd0, 5'd4);

    // Flush at N+10, restart sampled at N+12.
    drive_start(OP_DIVU, 32'd1000, 32'd10, 5'd7);
    repeat (10) tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check("flush_busy", {31'd0, busy_o}, 32'd0);
    check("flush_ready", {31'd0, ready_o}, 32'd0);
    drive_start(OP_DIVU, 32'd1000, 32'd10, 5'd8);
    wait_ready("after_flush", 34, 32'd100, 5'd8);

    // Second start while busy is ignored.
    drive_start(OP_DIVU, 32'd50, 32'd5, 5'd9);
    repeat (4) tick();
    op_i = OP_DIVU; dividend_i = 32'd77; divisor_i = 32'd1; reg_waddr_i = 5'd20;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    wait_ready("busy_restart", 29, 32'd10, 5'd9);

    // Start together with flush in IDLE: nothing happens.
    start_i = 1'b1;
    flush_i = 1'b1;
    #1;
    check("startflush_hold", {31'd0, hold_req_o}, 32'd0);
    tick();
    check("startflush_busy", {31'd0, busy_o}, 32'd0);
    start_i = 1'b0;
    flush_i = 1'b0;
    tick();
    check("startflush_busy2", {31'd0, busy_o}, 32'd0);

    // Reset mid-operation at N+20, released at N+22.
    drive_start(OP_DIVU, 32'd500, 32'd3, 5'd30);
    repeat (20) tick();
    rst     = 1'b0;
    start_i = 1'b1;
    #1;
    check("midrst_result", result_o, 32'd0);
    check("midrst_ready", {31'd0, ready_o}, 32'd0);
    check("midrst_waddr", {27'd0, reg_waddr_o}, 32'd0);
    check("midrst_busy", {31'd0, busy_o}, 32'd0);
    check("midrst_hold", {31'd0, hold_req_o}, 32'd0);
    tick();
    tick();
    start_i = 1'b0;
    rst     = 1'b1;
    pulses  = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (ready_o) pulses++;
    end
    check("postrst_no_ready", pulses, 32'd0);
    check("postrst_busy", {31'd0, busy_o}, 32'd0);
    drive_start(OP_DIVU, 32'd9, 32'd3, 5'd6);
    wait_ready("divu_9_3", 34, 32'd3, 5'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
